// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth UART receive path: receiver FSM
// states, the default bit period and the ASCII digit range used for
// song selection.
package bt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // 100 MHz clock divided down to 9600 baud.
    localparam int BIT_CYCLES_DEFAULT = 10417;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver core: double-flop synchroniser on the RX pin followed
// by a mid-bit sampling FSM. Emits the received byte on data together with
// a one-cycle valid pulse, but only when the stop bit reads high.
module uart_rx_core
    import bt_pkg::*;
#(
    parameter int BIT_CYCLES  = BIT_CYCLES_DEFAULT,
    parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxt,
    output logic [7:0] data,
    output logic       valid
);

    localparam logic [13:0] BIT_LAST  = 14'(BIT_CYCLES - 1);
    localparam logic [13:0] HALF_LAST = 14'(HALF_CYCLES - 1);

    logic        rx_m;
    logic        rx_s;
    rx_state_t   state;
    rx_state_t   state_next;
    logic [13:0] cnt;
    logic [13:0] cnt_next;
    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [7:0]  shreg;
    logic [7:0]  shreg_next;
    logic        valid_next;

    // Bring the asynchronous RX pin into the clock domain; preset high so a
    // reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rxt;
            rx_s <= rx_m;
        end
    end

    // Register the FSM state, bit timer, bit index, shift register and pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shreg <= shreg_next;
            valid <= valid_next;
        end
    end

    // Frame sequencing: confirm the start bit at its mid-point, then sample
    // each data bit and the stop bit one full bit period apart.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 14'd1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shreg_next[idx] = rx_s;
                    cnt_next        = '0;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 14'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    valid_next = rx_s;
                    state_next = IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt + 14'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // shreg only changes in DATA, so it is stable while valid is high.
    assign data = shreg;

endmodule

// File: rtl/bluetooth.sv
// Bluetooth serial front end for the piano game: receives 8N1 bytes, keeps
// the last good byte on out and turns ASCII digits '0'..'9' into a 4-bit
// song selection on choose.
module bluetooth
    import bt_pkg::*;
#(
    parameter int BIT_CYCLES  = BIT_CYCLES_DEFAULT,
    parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxt,
    output logic [3:0] choose,
    output logic [7:0] out
);

    logic [7:0] rx_data;
    logic       rx_valid;

    uart_rx_core #(
        .BIT_CYCLES (BIT_CYCLES),
        .HALF_CYCLES(HALF_CYCLES)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .rxt  (rxt),
        .data (rx_data),
        .valid(rx_valid)
    );

    // Latch each good byte; only digit bytes move the song selection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out    <= 8'h00;
            choose <= 4'h0;
        end else if (rx_valid) begin
            out <= rx_data;
            if (is_digit(rx_data)) begin
                choose <= 4'(rx_data - ASCII_ZERO);
            end
        end
    end

endmodule

// File: tb/tb_bluetooth.sv
// Randomised scoreboard bench for the bluetooth UART receiver: the stimulus
// side pushes the expected out/choose for every well-framed byte, and a
// monitor pops and compares each time the receiver delivers a byte.
module tb_bluetooth;

    localparam int BIT     = 16;
    localparam int HALF    = BIT / 2;
    localparam int MAX_LAT = 10 * BIT + 5;
    localparam int MIN_LAT = 9 * BIT;

    typedef struct {
        logic [7:0] b;
        logic [3:0] ch;
        int         start_cycle;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxt = 1'b1;
    logic [3:0] choose;
    logic [7:0] out;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;
    logic [7:0] exp_out    = 8'h00;
    logic [3:0] exp_choose = 4'h0;

    bluetooth #(
        .BIT_CYCLES (BIT),
        .HALF_CYCLES(HALF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rxt   (rxt),
        .choose(choose),
        .out   (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic compare(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic checkOutput(input string name);
        compare({name, "_out"}, int'(out), int'(exp_out));
        compare({name, "_choose"}, int'(choose), int'(exp_choose));
    endtask

    // Sends one 8N1 frame starting at the current negedge, then idles high
    // for gap bit periods. The reference model works from the byte value.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int gap);
        exp_t e;
        int   start;
        rxt   = 1'b0;
        start = cycle;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxt = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxt = stop_bit;
        if (stop_bit) begin
            exp_out = b;
            if (int'(b) >= 48 && int'(b) <= 57) begin
                exp_choose = 4'(int'(b) - 48);
            end
            e.b           = exp_out;
            e.ch          = exp_choose;
            e.start_cycle = start;
            sb.push_back(e);
        end
        repeat (BIT) @(negedge clk);
        rxt = 1'b1;
        repeat (gap * BIT) @(negedge clk);
    endtask

    // Monitor: one cycle after the receiver's valid pulse the registered
    // outputs must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (rst && dut.rx_valid) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: actual out 0x%0h, required no delivery", out);
                end else begin
                    e   = sb.pop_front();
                    lat = cycle - e.start_cycle;
                    compare("sb_out", int'(out), int'(e.b));
                    compare("sb_choose", int'(choose), int'(e.ch));
                    checks++;
                    if (lat < MIN_LAT || lat > MAX_LAT) begin
                        errors++;
                        $display("[TB] FAIL sb_latency: actual %0d cycles, required %0d..%0d",
                                 lat, MIN_LAT, MAX_LAT);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] b;
        logic       stop_bit;
        int         gap;

        rst = 1'b0;
        rxt = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset");

        // Short low pulse must not start a frame.
        rxt = 1'b0;
        repeat (3) @(negedge clk);
        rxt = 1'b1;
        repeat (10 * BIT) @(negedge clk);
        checkOutput("glitch");

        applyStimulus(8'h33, 1'b1, 1);
        checkOutput("digit3");
        applyStimulus(8'h41, 1'b1, 1);
        checkOutput("nondigit");
        applyStimulus(8'h37, 1'b0, 2);
        checkOutput("framing");
        applyStimulus(8'h35, 1'b1, 0);
        applyStimulus(8'h39, 1'b1, 1);
        checkOutput("back2back");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                b = 8'(48 + $urandom_range(0, 9));
            end else begin
                b = 8'($urandom_range(0, 255));
            end
            stop_bit = ($urandom_range(0, 7) != 0);
            gap      = stop_bit ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            applyStimulus(b, stop_bit, gap);
            checkOutput("random");
        end

        // Abort a frame part-way through with reset.
        applyStimulus(8'h36, 1'b1, 1);
        checkOutput("pre_abort");
        rxt = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxt = 1'b1;
            repeat (BIT) @(negedge clk);
        end
        rst = 1'b0;
        rxt = 1'b1;
        repeat (3) @(negedge clk);
        rst        = 1'b1;
        exp_out    = 8'h00;
        exp_choose = 4'h0;
        sb.delete();
        @(negedge clk);
        checkOutput("rst_abort");
        repeat (12 * BIT) @(negedge clk);
        checkOutput("rst_after");

        applyStimulus(8'h32, 1'b1, 2);
        checkOutput("post_reset");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: actual %0d pending, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
